// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Imported by mem_loader; see that file for the MEM_LOADER_VERIFY_EN build option.
package mem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_ADDR,
        HDR_LEN,
        DATA,
        WRITE,
        WAIT_W,
        READ,
        WAIT_R,
        DONE,
        ERROR
    } loader_state_t;

    localparam int         LOADER_HDR_BYTES  = 4;
    localparam logic [3:0] LOADER_WSTRB_WORD = 4'hF;

    // Place a stream byte into its little-endian lane of a 32-bit word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        result[lane*8 +: 8] = data;
        return result;
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader bus master: turns an addr/len/data byte stream into word writes.
// Define MEM_LOADER_VERIFY_EN to read back and compare every written word.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [1:0]  LAST_LANE = 2'(LOADER_HDR_BYTES - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    loader_state_t state_q, state_d;
    logic          run_q;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          rx_fire;

    // run_q keeps rx_ready low while reset is asserted even though state is IDLE.
    assign rx_ready = run_q && (state_q inside {IDLE, HDR_ADDR, HDR_LEN, DATA});
    assign rx_fire  = rx_valid && rx_ready;

    assign memory_instr = 1'b0;
    assign memory_addr  = addr_q;
    assign memory_wdata = wdata_q;
    assign load_busy    = state_q inside {DATA, WRITE, WAIT_W, READ, WAIT_R};
    assign load_done    = (state_q == DONE);
    assign load_error   = (state_q == ERROR);

`ifndef MEM_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^memory_rdata;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d      = state_q;
        lane_d       = lane_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wdata_d      = wdata_q;
        tmo_d        = tmo_q;
        memory_valid = 1'b0;
        memory_wstrb = 4'h0;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    addr_d  = insert_byte(32'h0, 2'd0, rx_data);
                    lane_d  = 2'd1;
                    state_d = HDR_ADDR;
                end
            end
            HDR_ADDR: begin
                if (rx_fire) begin
                    addr_d = insert_byte(addr_q, lane_q, rx_data);
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        state_d = (addr_d[1:0] != 2'b00) ? ERROR : HDR_LEN;
                    end
                end
            end
            HDR_LEN: begin
                if (rx_fire) begin
                    len_d  = insert_byte(len_q, lane_q, rx_data);
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        state_d = (len_d == 32'h0) ? DONE : DATA;
                    end
                end
            end
            DATA: begin
                if (rx_fire) begin
                    wdata_d = insert_byte(wdata_q, lane_q, rx_data);
                    lane_d  = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                memory_valid = 1'b1;
                memory_wstrb = LOADER_WSTRB_WORD;
                tmo_d        = 32'd1;
                state_d      = WAIT_W;
            end
            WAIT_W: begin
                memory_wstrb = LOADER_WSTRB_WORD;
                // A completion arriving on the timeout cycle still counts.
                if (memory_ready) begin
`ifdef MEM_LOADER_VERIFY_EN
                    state_d = READ;
`else
                    addr_d  = addr_q + 32'd4;
                    len_d   = len_q - 32'd1;
                    state_d = (len_q == 32'd1) ? DONE : DATA;
`endif
                end else if (tmo_q >= TMO_LIMIT) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            READ: begin
                memory_valid = 1'b1;
                tmo_d        = 32'd1;
                state_d      = WAIT_R;
            end
            WAIT_R: begin
                if (memory_ready) begin
                    if (memory_rdata != wdata_q) begin
                        state_d = ERROR;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        len_d   = len_q - 32'd1;
                        state_d = (len_q == 32'd1) ? DONE : DATA;
                    end
                end else if (tmo_q >= TMO_LIMIT) begin
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            lane_q  <= 2'd0;
            addr_q  <= 32'h0;
            len_q   <= 32'h0;
            wdata_q <= 32'h0;
            tmo_q   <= 32'h0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all update together at the edge.
            state_q <= state_d;
            run_q   <= 1'b1;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: scoreboard of expected bus requests plus a
// responding memory model; covers the MEM_LOADER_VERIFY_EN build when defined.
`timescale 1ns/1ps
module tb_mem_loader;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    mem_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
    } req_t;

    req_t        exp_q[$];
    req_t        cur;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [logic [31:0]];
    bit          resp_en = 1'b1;
    bit          resp_corrupt = 1'b0;
    int          resp_lat = 2;
    int          resp_cnt = 0;
    logic [31:0] resp_data = 32'h0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every request pulse is matched against the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && memory_valid) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            check("request_expected", 32'(exp_q.size() != 0), 32'd1);
            check("req_instr", 32'(memory_instr), 32'd0);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("req_addr", memory_addr, cur.addr);
                check("req_wstrb", 32'(memory_wstrb), 32'(cur.wstrb));
                if (cur.chk_wdata) check("req_wdata", memory_wdata, cur.wdata);
            end
        end
        prev_valid <= reset && memory_valid;
    end

    // Memory responder: answers each request resp_lat cycles later with a one-cycle ready.
    initial begin
        memory_ready = 1'b0;
        memory_rdata = 32'h0;
        forever begin
            @(negedge clock);
            memory_ready = 1'b0;
            if (!reset) begin
                resp_cnt = 0;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    memory_ready = 1'b1;
                    memory_rdata = resp_data;
                end
            end else if (memory_valid && resp_en) begin
                if (memory_wstrb == 4'hF) begin
                    mem[memory_addr] = memory_wdata;
                    resp_data = 32'h0;
                end else begin
                    resp_data = mem.exists(memory_addr) ? mem[memory_addr] : 32'h0;
                    if (resp_corrupt) resp_data = 32'h0;
                end
                resp_cnt = resp_lat - 1;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_valid"}, 32'(memory_valid), 32'd0);
        check({tag, "_addr"}, memory_addr, 32'd0);
        check({tag, "_wdata"}, memory_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(memory_wstrb), 32'd0);
        check({tag, "_flags"}, {29'd0, load_busy, load_done, load_error}, 32'd0);
    endtask

    task automatic do_reset();
        rx_valid     = 1'b0;
        reset        = 1'b0;
        resp_en      = 1'b1;
        resp_corrupt = 1'b0;
        repeat (2) @(negedge clock);
        check_zero("rst");
        check("scoreboard_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clock);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
        ok = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < budget; i++) begin
            if (rx_ready) begin
                @(posedge clock);
                ok = 1'b1;
                @(negedge clock);
                break;
            end
            @(negedge clock);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        bit k;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[i*8 +: 8], 200, k);
            ok = ok & k;
        end
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] w);
        exp_q.push_back('{a, w, 4'hF, 1'b1});
`ifdef MEM_LOADER_VERIFY_EN
        exp_q.push_back('{a, w, 4'h0, 1'b0});
`endif
    endtask

    task automatic wait_end(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_done || load_error) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("end_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic check_final(input string tag, input bit done, input bit err);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_error"}, 32'(load_error), 32'(err));
        check({tag, "_busy"}, 32'(load_busy), 32'd0);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    endtask

    logic [31:0] words[$];
    logic [31:0] base;
    int          len;
    bit          ok;
    int          cycles;

    initial begin
        #(800_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reference: one image of 0xDEADBEEF at 0x1000.
        do_reset();
        expect_word(32'h0000_1000, 32'hDEAD_BEEF);
        send_word(32'h0000_1000, ok);
        send_word(32'd1, ok);
        send_word(32'hDEAD_BEEF, ok);
        wait_end(100);
        check_final("basic", 1'b1, 1'b0);
        send_byte(8'h55, 5, ok);
        check("done_rejects_bytes", 32'(ok), 32'd0);

        // Misaligned header address.
        do_reset();
        send_word(32'h0000_1002, ok);
        check_final("misaligned", 1'b0, 1'b1);

        // Zero-length image completes without touching the bus.
        do_reset();
        send_word(32'h0000_2000, ok);
        send_word(32'd0, ok);
        check_final("len0", 1'b1, 1'b0);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        expect_word(32'hFFFF_FFFC, 32'h1122_3344);
        expect_word(32'h0000_0000, 32'h5566_7788);
        send_word(32'hFFFF_FFFC, ok);
        send_word(32'd2, ok);
        send_word(32'h1122_3344, ok);
        send_word(32'h5566_7788, ok);
        wait_end(200);
        check_final("wrap", 1'b1, 1'b0);

        // Memory never answers: error exactly TMO cycles after the request pulse.
        do_reset();
        resp_en = 1'b0;
        exp_q.push_back('{32'h0000_3000, 32'hCAFE_F00D, 4'hF, 1'b1});
        send_word(32'h0000_3000, ok);
        send_word(32'd1, ok);
        send_word(32'hCAFE_F00D, ok);
        check("timeout_valid_seen", 32'(memory_valid), 32'd1);
        cycles = 0;
        for (int i = 1; i <= 4 * TMO; i++) begin
            @(negedge clock);
            if (load_error) begin
                cycles = i;
                break;
            end
        end
        check("timeout_cycles", 32'(cycles), 32'(TMO));
        check_final("timeout", 1'b0, 1'b1);

        // Reset asserted while waiting for a write completion.
        do_reset();
        resp_en = 1'b0;
        exp_q.push_back('{32'h0000_4000, 32'h0BAD_CAFE, 4'hF, 1'b1});
        send_word(32'h0000_4000, ok);
        send_word(32'd1, ok);
        send_word(32'h0BAD_CAFE, ok);
        repeat (3) @(negedge clock);
        check("midwait_busy", 32'(load_busy), 32'd1);
        reset = 1'b0;
        #1;
        check_zero("midwait_rst");

`ifdef MEM_LOADER_VERIFY_EN
        // Readback returns zero: first word must fail verification.
        do_reset();
        resp_corrupt = 1'b1;
        expect_word(32'h0000_5000, 32'hDEAD_BEEF);
        send_word(32'h0000_5000, ok);
        send_word(32'd2, ok);
        send_word(32'hDEAD_BEEF, ok);
        wait_end(100);
        check_final("verify_bad", 1'b0, 1'b1);
`endif

        // Randomised images with random memory latency and stream gaps.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            resp_lat = int'($urandom_range(2, 5));
            base     = $urandom() & 32'hFFFF_FFFC;
            len      = int'($urandom_range(1, 4));
            words.delete();
            for (int i = 0; i < len; i++) begin
                words.push_back($urandom());
                expect_word(base + 32'(4 * i), words[i]);
            end
            send_word(base, ok);
            send_word(32'(len), ok);
            for (int i = 0; i < len; i++) send_word(words[i], ok);
            wait_end(200);
            check_final("rand", 1'b1, 1'b0);
            for (int i = 0; i < len; i++) begin
                check("rand_mem_content",
                      mem.exists(base + 32'(4 * i)) ? mem[base + 32'(4 * i)] : 32'hXXXX_XXXX,
                      words[i]);
            end
        end

        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
